// File: rtl/arm_mc_controller_pkg.sv
// Shared types and encodings for the multi-cycle ARM control unit.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath signal bundle: instruction fields and ALU flags in, control out.
interface arm_mc_controller_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ResultSrc;

  modport master (
    input  Op, Funct, Rd, Cond, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ALUControl, ResultSrc
  );

  modport slave (
    output Op, Funct, Rd, Cond, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ALUControl, ResultSrc
  );
endinterface

// File: rtl/arm_mc_controller_cond_check.sv
// ARM condition-code evaluation against stored NZCV; the never (1111) code is false.
module cond_check
  import arm_mc_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       cond_ex_o
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags_i;

  always_comb begin
    cond_ex_o = 1'b0;
    case (cond_i)
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~c | z;
      COND_GE: cond_ex_o = (n == v);
      COND_LT: cond_ex_o = (n != v);
      COND_GT: cond_ex_o = ~z & (n == v);
      COND_LE: cond_ex_o = z | (n != v);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/arm_mc_controller.sv
// Moore control FSM for the multi-cycle ARM datapath, with NZCV flags and condition gating.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  arm_mc_controller_if.master        bus
);
  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_q, cond_d;
  logic       cond_ex;

  logic [3:0] cmd;
  logic [1:0] alu_dec;
  logic       no_write, cv_upd, wb_en, rd_is_pc, exec_st;

  logic       pc_write, mem_write, reg_write, ir_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, alu_control, result_src;

  cond_check u_cond_check (
    .cond_i    (bus.Cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  always_comb begin
    cmd      = bus.Funct[4:1];
    alu_dec  = ALU_ADD;
    no_write = 1'b0;
    cv_upd   = 1'b0;
    case (cmd)
      4'b0100: begin alu_dec = ALU_ADD; cv_upd = 1'b1; end
      4'b0010: begin alu_dec = ALU_SUB; cv_upd = 1'b1; end
      4'b0000: alu_dec = ALU_AND;
      4'b1100: alu_dec = ALU_ORR;
      4'b1010: begin alu_dec = ALU_SUB; cv_upd = 1'b1; no_write = 1'b1; end
      default: begin alu_dec = ALU_ADD; no_write = 1'b1; end
    endcase
  end

  // cmd bits of a memory word are addressing-mode bits, so NoWrite only applies to DP
  assign wb_en    = cond_q & ~(no_write & (bus.Op == OP_DP));
  assign rd_is_pc = (bus.Rd == 4'd15);
  assign exec_st  = (state_q == EXECR) || (state_q == EXECI);

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    alu_control = ALU_ADD;
    result_src  = RES_ALUOUT;
    case (state_q)
      FETCH: begin
        state_d    = DECODE;
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        case (bus.Op)
          OP_DP:   state_d = bus.Funct[5] ? EXECI : EXECR;
          OP_MEM:  state_d = MEMADR;
          OP_BR:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_d   = bus.Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        if (rd_is_pc) pc_write = wb_en;
        else          reg_write = wb_en;
        state_d = FETCH;
      end
      MEMWR: begin
        adr_src   = 1'b1;
        mem_write = cond_q;
        state_d   = FETCH;
      end
      EXECR: begin
        alu_control = alu_dec;
        state_d     = ALUWB;
      end
      EXECI: begin
        alu_src_b   = SRCB_IMM;
        alu_control = alu_dec;
        state_d     = ALUWB;
      end
      ALUWB: begin
        if (rd_is_pc) pc_write = wb_en;
        else          reg_write = wb_en;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = cond_q;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (exec_st && bus.Funct[0] && cond_q) begin
      flags_d[3:2] = bus.ALUFlags[3:2];
      if (cv_upd) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  assign cond_d = (state_q == DECODE) ? cond_ex : cond_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= '0;
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cond_q  <= cond_d;
    end
  end

  // Reset must suppress architectural writes even when it lands mid-instruction.
  assign bus.PCWrite    = pc_write  & ~reset;
  assign bus.MemWrite   = mem_write & ~reset;
  assign bus.RegWrite   = reg_write & ~reset;
  assign bus.IRWrite    = ir_write  & ~reset;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.ResultSrc  = result_src;
endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: per-cycle control vectors and flag register contents.
module tb_arm_mc_controller;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  arm_mc_controller_if bus ();

  arm_mc_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] outv;
  assign outv = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ResultSrc};

  function automatic logic [11:0] v(input logic pcw, input logic mw, input logic rw,
                                    input logic irw, input logic adr, input logic sa,
                                    input logic [1:0] sb, input logic [1:0] ac,
                                    input logic [1:0] rs);
    return {pcw, mw, rw, irw, adr, sa, sb, ac, rs};
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [11:0] exp);
    @(posedge clk);
    #1;
    check(tag, outv, exp);
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
    check(tag, {8'h00, dut.flags_q}, {8'h00, exp});
  endtask

  task automatic instr(input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rd, input logic [3:0] cnd);
    bus.Op    = op;
    bus.Funct = funct;
    bus.Rd    = rd;
    bus.Cond  = cnd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [11:0] V_FETCH, V_FETCH_RST, V_DECODE, V_MEMADR, V_MEMRD, V_EXECI_ADD, V_ZERO;
    V_FETCH     = v(1, 0, 0, 1, 0, 1, 2'b10, 2'b00, 2'b10);
    V_FETCH_RST = v(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10);
    V_DECODE    = v(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10);
    V_MEMADR    = v(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    V_MEMRD     = v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00);
    V_EXECI_ADD = v(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00);
    V_ZERO      = '0;

    reset = 1'b1;
    bus.ALUFlags = 4'b0000;
    instr(2'b01, 6'b011000, 4'd3, 4'b1110);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outv, V_FETCH_RST);
    chk_flags("reset_flags", 4'b0000);
    reset = 1'b0;
    #1;
    check("fetch_after_init", outv, V_FETCH);

    // STR interrupted by a 3-cycle reset while in MEMWR
    step("str_decode", V_DECODE);
    step("str_memadr", V_MEMADR);
    step("str_memwr", v(0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
    reset = 1'b1;
    #1;
    check("str_memwr_in_reset", outv, v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
    step("rst_cycle2", V_FETCH_RST);
    step("rst_cycle3", V_FETCH_RST);
    reset = 1'b0;
    #1;
    check("fetch_after_reset", outv, V_FETCH);

    // ADDS R1, #imm: N=0 Z=1 C=1 V=0 from the ALU
    instr(2'b00, 6'b101001, 4'd1, 4'b1110);
    step("adds_decode", V_DECODE);
    step("adds_execi", V_EXECI_ADD);
    bus.ALUFlags = 4'b0110;
    step("adds_aluwb", v(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    chk_flags("adds_flags", 4'b0110);
    bus.ALUFlags = 4'b1111;
    step("adds_next_fetch", V_FETCH);

    // CMP sets Z, no register write
    instr(2'b00, 6'b010101, 4'd0, 4'b1110);
    step("cmp_decode", V_DECODE);
    step("cmp_execr", v(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    bus.ALUFlags = 4'b0100;
    step("cmp_aluwb", V_ZERO);
    chk_flags("cmp_flags", 4'b0100);
    step("cmp_next_fetch", V_FETCH);

    // BEQ taken with Z=1
    instr(2'b10, 6'b100000, 4'd0, 4'b0000);
    step("beq_decode", V_DECODE);
    step("beq_branch", v(1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10));
    step("beq_next_fetch", V_FETCH);

    // BNE not taken with Z=1
    instr(2'b10, 6'b100000, 4'd0, 4'b0001);
    step("bne_decode", V_DECODE);
    step("bne_branch", v(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10));
    step("bne_next_fetch", V_FETCH);

    // ADDSNE with Z=1: condition fails, flags and registers untouched
    instr(2'b00, 6'b101001, 4'd2, 4'b0001);
    step("addsne_decode", V_DECODE);
    step("addsne_execi", V_EXECI_ADD);
    bus.ALUFlags = 4'b0000;
    step("addsne_aluwb", V_ZERO);
    chk_flags("addsne_flags", 4'b0100);
    step("addsne_next_fetch", V_FETCH);

    // ADDS producing C=1 only, then ANDS keeps C and V
    instr(2'b00, 6'b101001, 4'd4, 4'b1110);
    step("adds2_decode", V_DECODE);
    step("adds2_execi", V_EXECI_ADD);
    bus.ALUFlags = 4'b0010;
    step("adds2_aluwb", v(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    chk_flags("adds2_flags", 4'b0010);
    step("adds2_next_fetch", V_FETCH);

    instr(2'b00, 6'b100001, 4'd5, 4'b1110);
    step("ands_decode", V_DECODE);
    step("ands_execi", v(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00));
    bus.ALUFlags = 4'b1000;
    step("ands_aluwb", v(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    chk_flags("ands_flags", 4'b1010);
    step("ands_next_fetch", V_FETCH);

    // ORR R15 (no S) under MI with N=1: writes PC instead of a register
    instr(2'b00, 6'b011000, 4'd15, 4'b0100);
    step("orr_pc_decode", V_DECODE);
    step("orr_pc_execr", v(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00));
    bus.ALUFlags = 4'b0101;
    step("orr_pc_aluwb", v(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    chk_flags("orr_pc_flags", 4'b1010);
    step("orr_pc_next_fetch", V_FETCH);

    // LDR into R15
    instr(2'b01, 6'b011001, 4'd15, 4'b1110);
    step("ldr_decode", V_DECODE);
    step("ldr_memadr", V_MEMADR);
    step("ldr_memrd", V_MEMRD);
    step("ldr_memwb", v(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01));
    step("ldr_next_fetch", V_FETCH);

    // Unsupported Op: straight back to FETCH
    instr(2'b11, 6'b111111, 4'd7, 4'b1110);
    step("nop_decode", V_DECODE);
    step("nop_next_fetch", V_FETCH);

    // Condition 1111 never executes: STR with no memory write
    instr(2'b01, 6'b011000, 4'd1, 4'b1111);
    step("strnv_decode", V_DECODE);
    step("strnv_memadr", V_MEMADR);
    step("strnv_memwr", v(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00));
    step("strnv_next_fetch", V_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
